// File: rtl/aes_mode_ctrl.sv
// Block-chaining controller (ECB/CBC/CTR) sequencing an external AES128 core one block at a time.
// Optional output-handshake counter port o_BlkCnt is enabled by defining AES_MODE_BLKCNT_EN.
module aes_mode_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CTR_W      = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         i_fInit,
    input  logic [127:0] i_Key,
    input  logic [127:0] i_Iv,
    input  logic [1:0]   i_Mode,
    input  logic         i_fDec,
    input  logic         i_Valid,
    input  logic [127:0] i_Data,
    output logic         o_Ready,
    output logic         o_Valid,
    output logic [127:0] o_Data,
    input  logic         i_Ready,
    output logic         o_Busy,
    output logic         o_CoreStart,
    output logic         o_CoreDec,
    output logic [127:0] o_CoreData,
    output logic [127:0] o_CoreKey,
    input  logic [127:0] i_CoreData,
    input  logic         i_CoreDone
`ifdef AES_MODE_BLKCNT_EN
    ,
    output logic [31:0]  o_BlkCnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    // Selects the counter increment field; a 128-bit field wraps to all ones.
    localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;
    localparam logic [1:0] MODE_ECB = 2'b00;
    localparam logic [1:0] MODE_CBC = 2'b01;
    localparam logic [1:0] MODE_CTR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t             state_r;
    logic [127:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r, count_next_s;
    logic               ready_r;
    logic               push_s, pop_s, busy_s, init_s;
    logic [127:0]       head_s;
    logic [127:0]       key_r, chain_r, ctr_r, d_r, core_data_r, data_r;
    logic [1:0]         mode_r;
    logic               dec_r, core_dec_r, core_start_r, valid_r;

    function automatic logic [127:0] core_input(input logic [1:0] mode, input logic dec,
                                                 input logic [127:0] d, input logic [127:0] c,
                                                 input logic [127:0] n);
        logic [127:0] res;
        case (mode)
            MODE_CBC: res = dec ? d : (d ^ c);
            MODE_CTR: res = n;
            default:  res = d;
        endcase
        return res;
    endfunction

    function automatic logic [127:0] result_of(input logic [1:0] mode, input logic dec,
                                                input logic [127:0] d, input logic [127:0] c,
                                                input logic [127:0] r);
        logic [127:0] res;
        case (mode)
            MODE_CBC: res = dec ? (r ^ c) : r;
            MODE_CTR: res = r ^ d;
            default:  res = r;
        endcase
        return res;
    endfunction

    function automatic logic [127:0] chain_next(input logic [1:0] mode, input logic dec,
                                                 input logic [127:0] d, input logic [127:0] c,
                                                 input logic [127:0] r);
        logic [127:0] res;
        case (mode)
            MODE_CBC: res = dec ? d : r;
            default:  res = c;
        endcase
        return res;
    endfunction

    function automatic logic [127:0] ctr_next(input logic [1:0] mode, input logic [127:0] n);
        logic [127:0] res;
        case (mode)
            MODE_CTR: res = (n & ~CTR_MASK) | ((n + 128'd1) & CTR_MASK);
            default:  res = n;
        endcase
        return res;
    endfunction

    assign busy_s = (count_r != CNT_ZERO) || (state_r != S_IDLE) || valid_r;
    assign init_s = i_fInit && !busy_s;
    assign head_s = mem_r[rd_ptr_r];

    // FIFO handshake and occupancy bookkeeping
    always_comb begin
        push_s       = i_Valid && ready_r;
        pop_s        = (state_r == S_LOAD);
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage; contents are meaningless until the write pointer covers them
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_Data;
        end
    end

    // FIFO pointers, count and registered ready flag
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != DEPTH_C);
        end
    end

    // Block sequencing FSM with chaining state and all registered core/output signals
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r      <= S_IDLE;
            key_r        <= 128'd0;
            chain_r      <= 128'd0;
            ctr_r        <= 128'd0;
            mode_r       <= MODE_ECB;
            dec_r        <= 1'b0;
            d_r          <= 128'd0;
            core_data_r  <= 128'd0;
            core_dec_r   <= 1'b0;
            core_start_r <= 1'b0;
            data_r       <= 128'd0;
            valid_r      <= 1'b0;
        end else begin
            core_start_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (init_s) begin
                        key_r   <= i_Key;
                        mode_r  <= i_Mode;
                        dec_r   <= i_fDec;
                        chain_r <= i_Iv;
                        ctr_r   <= i_Iv;
                    end
                    if (count_r != CNT_ZERO) begin
                        state_r <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    d_r          <= head_s;
                    core_data_r  <= core_input(mode_r, dec_r, head_s, chain_r, ctr_r);
                    core_dec_r   <= (mode_r == MODE_CTR) ? 1'b0 : dec_r;
                    core_start_r <= 1'b1;
                    state_r      <= S_START;
                end
                S_START: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_CoreDone) begin
                        data_r  <= result_of(mode_r, dec_r, d_r, chain_r, i_CoreData);
                        chain_r <= chain_next(mode_r, dec_r, d_r, chain_r, i_CoreData);
                        ctr_r   <= ctr_next(mode_r, ctr_r);
                        valid_r <= 1'b1;
                        state_r <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_Ready) begin
                        valid_r <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AES_MODE_BLKCNT_EN
    logic [31:0] blk_cnt_r;

    // Output handshake counter, cleared by reset or an accepted init
    always_ff @(posedge Clk) begin
        if (Rst) begin
            blk_cnt_r <= 32'd0;
        end else if (init_s) begin
            blk_cnt_r <= 32'd0;
        end else if (valid_r && i_Ready) begin
            blk_cnt_r <= blk_cnt_r + 32'd1;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    assign o_BlkCnt = blk_cnt_r;
`endif

    assign o_Ready     = ready_r;
    assign o_Valid     = valid_r;
    assign o_Data      = data_r;
    assign o_Busy      = busy_s;
    assign o_CoreStart = core_start_r;
    assign o_CoreDec   = core_dec_r;
    assign o_CoreData  = core_data_r;
    assign o_CoreKey   = key_r;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl; a behavioural core stand-in answers each o_CoreStart.
// The stand-in returns the FIPS-197 vector for the known key/block pair, else an invertible rotate-xor.
module tb_aes_mode_ctrl;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] IV4 = 128'h000102030405060708090a0bffffffff;
    localparam logic [127:0] IV4_NEXT = 128'h000102030405060708090a0b00000000;
    localparam logic [127:0] KBAD = 128'hffeeddccbbaa99887766554433221100;

    logic         Clk, Rst, i_fInit, i_fDec, i_Valid, i_Ready, i_CoreDone;
    logic [127:0] i_Key, i_Iv, i_Data, i_CoreData;
    logic [1:0]   i_Mode;
    logic         o_Ready, o_Valid, o_Busy, o_CoreStart, o_CoreDec;
    logic [127:0] o_Data, o_CoreData, o_CoreKey;
`ifdef AES_MODE_BLKCNT_EN
    logic [31:0]  o_BlkCnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    int start_cycles = 0;
    logic [127:0] cap_q[$];
    logic         dec_q[$];
    logic [127:0] core_res;
    logic [127:0] e_a, e_b;
    int accepted;
    int snap;

    aes_mode_ctrl #(.FIFO_DEPTH(4), .CTR_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .i_fInit(i_fInit), .i_Key(i_Key), .i_Iv(i_Iv),
        .i_Mode(i_Mode), .i_fDec(i_fDec), .i_Valid(i_Valid), .i_Data(i_Data),
        .o_Ready(o_Ready), .o_Valid(o_Valid), .o_Data(o_Data), .i_Ready(i_Ready),
        .o_Busy(o_Busy), .o_CoreStart(o_CoreStart), .o_CoreDec(o_CoreDec),
        .o_CoreData(o_CoreData), .o_CoreKey(o_CoreKey), .i_CoreData(i_CoreData),
        .i_CoreDone(i_CoreDone)
`ifdef AES_MODE_BLKCNT_EN
        , .o_BlkCnt(o_BlkCnt)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [127:0] core_fn(input logic [127:0] x, input logic [127:0] k,
                                              input logic dec);
        logic [127:0] t;
        if (k == K0 && !dec && x == P0) return C0;
        if (k == K0 && dec && x == C0) return P0;
        if (!dec) return {x[126:0], x[127]} ^ k;
        t = x ^ k;
        return {t[0], t[127:1]};
    endfunction

    // Core stand-in: fixed 3-cycle latency after each start pulse
    initial begin
        i_CoreDone = 1'b0;
        i_CoreData = 128'd0;
        forever begin
            @(posedge Clk); #1;
            if (o_CoreStart) begin
                cap_q.push_back(o_CoreData);
                dec_q.push_back(o_CoreDec);
                core_res = core_fn(o_CoreData, o_CoreKey, o_CoreDec);
                repeat (3) @(posedge Clk);
                #1;
                i_CoreData = core_res;
                i_CoreDone = 1'b1;
                @(posedge Clk); #1;
                i_CoreDone = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clk); #1;
            if (o_CoreStart) start_cycles++;
        end
    end

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_init(input logic [127:0] k, input logic [127:0] iv,
                           input logic [1:0] m, input logic d);
        i_Key = k; i_Iv = iv; i_Mode = m; i_fDec = d; i_fInit = 1'b1;
        tick();
        i_fInit = 1'b0;
    endtask

    task automatic push(input string tag, input logic [127:0] data);
        int n;
        n = 0;
        i_Valid = 1'b1;
        i_Data = data;
        while (!o_Ready && n < 100) begin tick(); n++; end
        chk({tag, "_push_ready"}, o_Ready, 1'b1);
        tick();
        i_Valid = 1'b0;
    endtask

    task automatic get_out(input string tag, input logic [127:0] exp);
        int n;
        n = 0;
        i_Ready = 1'b1;
        while (!o_Valid && n < 100) begin tick(); n++; end
        chk({tag, "_valid"}, o_Valid, 1'b1);
        chk(tag, o_Data, exp);
        tick();
        i_Ready = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; i_fInit = 1'b0; i_Key = 128'd0; i_Iv = 128'd0; i_Mode = 2'b00;
        i_fDec = 1'b0; i_Valid = 1'b0; i_Data = 128'd0; i_Ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", o_Valid, 1'b0);
        chk("rst_ready", o_Ready, 1'b0);
        chk("rst_busy", o_Busy, 1'b0);
        chk("rst_data", o_Data, 128'd0);
        chk("rst_key", o_CoreKey, 128'd0);
        chk("rst_start", o_CoreStart, 1'b0);
        Rst = 1'b0;
        tick();
        chk("ready_after_rst", o_Ready, 1'b1);

        // 1: ECB encrypt
        do_init(K0, 128'd0, 2'b00, 1'b0);
        chk("t1_key", o_CoreKey, K0);
        snap = start_cycles;
        push("t1", P0);
        get_out("t1_ecb_enc", C0);
        chk("t1_one_start", 128'(start_cycles - snap), 128'd1);
        chk("t1_busy_end", o_Busy, 1'b0);

        // 2: ECB decrypt
        do_init(K0, 128'd0, 2'b00, 1'b1);
        push("t2", C0);
        get_out("t2_ecb_dec", P0);

        // 3: CBC encrypt then decrypt, IV 0
        e_b = core_fn(P0 ^ C0, K0, 1'b0);
        do_init(K0, 128'd0, 2'b01, 1'b0);
        push("t3a", P0);
        push("t3b", P0);
        get_out("t3_cbc_enc0", C0);
        get_out("t3_cbc_enc1", e_b);
        chk("t3_enc1_differs", 128'(e_b != C0), 128'd1);
        do_init(K0, 128'd0, 2'b01, 1'b1);
        push("t3c", C0);
        push("t3d", e_b);
        get_out("t3_cbc_dec0", P0);
        get_out("t3_cbc_dec1", P0);

        // 4: CTR with counter wrap in the low 32 bits; i_fDec must be ignored
        e_a = core_fn(IV4, K0, 1'b0) ^ P0;
        e_b = core_fn(IV4_NEXT, K0, 1'b0) ^ P1;
        cap_q.delete();
        dec_q.delete();
        do_init(K0, IV4, 2'b10, 1'b1);
        push("t4a", P0);
        push("t4b", P1);
        get_out("t4_ctr0", e_a);
        get_out("t4_ctr1", e_b);
        chk("t4_ncap", 128'(cap_q.size()), 128'd2);
        chk("t4_core_in0", cap_q[0], IV4);
        chk("t4_core_in1", cap_q[1], IV4_NEXT);
        chk("t4_core_dec", dec_q[0], 1'b0);
        do_init(K0, IV4, 2'b10, 1'b0);
        push("t4c", e_a);
        push("t4d", e_b);
        get_out("t4_back0", P0);
        get_out("t4_back1", P1);

        // 5: backpressure, six blocks offered with i_Ready low
        do_init(K0, 128'd0, 2'b00, 1'b0);
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            int n;
            n = 0;
            i_Valid = 1'b1;
            i_Data = 128'(i + 1);
            while (!o_Ready && n < 40) begin tick(); n++; end
            if (o_Ready) begin
                tick();
                accepted++;
            end
        end
        i_Valid = 1'b0;
        chk("t5_accepted", 128'(accepted), 128'd5);
        chk("t5_ready_low", o_Ready, 1'b0);
        for (int i = 0; i < 4; i++) get_out("t5_order", core_fn(128'(i + 1), K0, 1'b0));
        chk("t5_busy_before_last", o_Busy, 1'b1);
        get_out("t5_last", core_fn(128'd5, K0, 1'b0));
        chk("t5_busy_after", o_Busy, 1'b0);

        // 6: reset while the core is working
        do_init(K0, 128'd0, 2'b01, 1'b0);
        push("t6a", P0);
        push("t6b", P1);
        begin
            int n;
            n = 0;
            while (!o_CoreStart && n < 40) begin tick(); n++; end
            chk("t6_start_seen", o_CoreStart, 1'b1);
        end
        tick();
        Rst = 1'b1;
        tick();
        chk("t6_rst_valid", o_Valid, 1'b0);
        chk("t6_rst_data", o_Data, 128'd0);
        chk("t6_rst_key", o_CoreKey, 128'd0);
        chk("t6_rst_coredata", o_CoreData, 128'd0);
        chk("t6_rst_busy", o_Busy, 1'b0);
        Rst = 1'b0;
        snap = start_cycles;
        repeat (10) tick();
        chk("t6_late_done_valid", o_Valid, 1'b0);
        chk("t6_no_restart", 128'(start_cycles - snap), 128'd0);
        chk("t6_fifo_flushed", o_Busy, 1'b0);

        // 6b: init while busy is ignored (key and ECB mode kept)
        do_init(K0, 128'd0, 2'b00, 1'b0);
        push("t6c", P1);
        push("t6d", P0);
        repeat (8) tick();
        chk("t6_busy_held", o_Busy, 1'b1);
        do_init(KBAD, 128'h1, 2'b01, 1'b1);
        chk("t6_key_kept", o_CoreKey, K0);
        get_out("t6_out0", core_fn(P1, K0, 1'b0));
        get_out("t6_out1", C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
Block-chaining controller placed in front of the AES128 core. It buffers plaintext or ciphertext blocks in a parametrised input FIFO and sequences the core through one block at a time. It applies ECB, CBC or CTR chaining around each core operation and returns results over a valid/ready output port. The core connects through dedicated core-side ports; this block does not instantiate it.

Parameters:
FIFO_DEPTH, 4, input FIFO depth in 128-bit blocks; power of two, minimum 2.
CTR_W, 32, width of the CTR-mode increment field, taken from the LSBs of the counter block; range 8..128.

Ports:
Clk  in  1  clock
Rst  in  1  reset
i_fInit  in  1  one-cycle pulse; loads i_Key, i_Iv, i_Mode, i_fDec
i_Key  in  128  cipher key
i_Iv  in  128  IV (CBC) or initial counter block (CTR)
i_Mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved (behaves as ECB)
i_fDec  in  1  1 = decrypt (ignored in CTR)
i_Valid  in  1  input block valid
i_Data  in  128  input block
o_Ready  out  1  FIFO can accept a block
o_Valid  out  1  output block valid
o_Data  out  128  output block
i_Ready  in  1  downstream accepts output
o_Busy  out  1  FIFO non-empty, FSM not IDLE, or o_Valid high
o_CoreStart  out  1  one-cycle start pulse to the core
o_CoreDec  out  1  core direction
o_CoreData  out  128  core input block
o_CoreKey  out  128  registered key
i_CoreData  in  128  core result
i_CoreDone  in  1  core done pulse

Behaviour:
- Interface: one clock, Clk. Rst is synchronous, active-high.
- Reset values: all outputs 0; key, chain and counter registers 0; mode ECB; FIFO empty; FSM IDLE.
- Init: i_fInit takes effect only when o_Busy=0; otherwise it is ignored. It loads key, mode and dec. It loads i_Iv into both the chain register and the counter register.
- FIFO:
  - Push when i_Valid && o_Ready. o_Ready = !full.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop may occur in the same cycle; count is unchanged and no data is lost.
- FSM:
  - IDLE -> LOAD when FIFO is non-empty.
  - LOAD: pop the head block into register D; form o_CoreData and o_CoreDec.
  - START: o_CoreStart=1 for exactly one cycle.
  - WAIT: on i_CoreDone, compute the result and register it to o_Data; set o_Valid the next cycle.
  - OUT: hold o_Data and o_Valid until i_Ready, then -> IDLE.
  - i_CoreDone outside WAIT is ignored.
- Chaining (C = chain register, N = counter register, R = i_CoreData):
  - ECB: core_in = D; out = R; o_CoreDec = dec.
  - CBC enc: core_in = D^C; out = R; C <= R.
  - CBC dec: core_in = D; out = R^C; C <= D.
  - CTR: core_in = N; out = R^D; o_CoreDec = 0. N[CTR_W-1:0] increments modulo 2^CTR_W; N[127:CTR_W] is unchanged.
- Chain and counter update in the same cycle o_Data is captured.
- Minimum overhead is 4 cycles per block plus core latency. Output order equals input order.
- o_CoreKey is constant between inits.
- Rst mid-operation: abandon the in-flight block, discard FIFO contents, no further o_CoreStart. The core is reset by the same Rst.

Optional Feature:
AES_MODE_BLKCNT_EN:
- Defined: adds output port o_BlkCnt[31:0]. It counts output handshakes (o_Valid && i_Ready), clears on Rst and on accepted i_fInit, and wraps at 2^32.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. ECB enc, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> o_Data 69c4e0d86a7b0430d8cdb78070b4c55a, one o_Valid handshake, exactly one o_CoreStart pulse.
2. ECB dec, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a -> o_Data 00112233445566778899aabbccddeeff.
3. CBC enc, IV 0, two identical blocks 00112233...eeff -> first 69c4e0d8...c55a; second = AES(P^first) and differs from first. CBC dec of both with IV 0 -> P, P.
4. CTR, CTR_W=32, IV 000102030405060708090a0bffffffff, two blocks -> o_CoreData = IV, then 000102030405060708090a0b00000000. Re-init with the same IV and feed the outputs back -> original plaintext.
5. Backpressure, FIFO_DEPTH=4, i_Ready=0, six blocks offered -> five accepted and o_Ready low. Release i_Ready -> five outputs in input order; o_Busy falls after the last handshake.
6. Rst asserted in WAIT -> all outputs 0 on the next edge. A later i_CoreDone is ignored. i_fInit while o_Busy=1 is ignored and the mode is unchanged.
